// File: rtl/jt12_pkg.sv
// Shared constants for the JT12 bus responder.
// Status byte layout, address-bus bit roles and the busy counter width live
// here so the responder and anything decoding dout agree on them.
package jt12_pkg;

  // Status byte bit positions on dout
  localparam int STAT_BUSY  = 7;
  localparam int STAT_FLAGB = 1;
  localparam int STAT_FLAGA = 0;

  // Address bus bit roles
  localparam int ADDR_SEL_BIT = 0;  // 0 = address write, 1 = data write
  localparam int BANK_BIT     = 1;  // 0 = regs 0xx, 1 = regs 1xx

  // Busy counter width
  localparam int CNT_W = 8;

  typedef enum logic {
    WR_ADDR = 1'b0,
    WR_DATA = 1'b1
  } wr_kind_e;

  // Assemble the status byte {busy, 5'b0, flag_b, flag_a}
  function automatic logic [7:0] status_byte(input logic busy,
                                             input logic flag_b,
                                             input logic flag_a);
    logic [7:0] s;
    s             = 8'h00;
    s[STAT_BUSY]  = busy;
    s[STAT_FLAGB] = flag_b;
    s[STAT_FLAGA] = flag_a;
    return s;
  endfunction

endpackage

// File: rtl/jt12_bus_resp_if.sv
// CPU bus plus MMR write-port bundle for jt12_bus_resp.
// master : host/test driver side (drives cs_n/wr_n/addr/din and timer flags)
// slave  : the responder (returns dout, write strobes, busy and err)
//
// Write semantics: a write is active while cs_n=0 and wr_n=0. The responder
// acts once per low strobe, on the first clock edge where the write is
// active; holding the strobe low longer does not repeat the write. There is
// no back-pressure: every write is taken, and busy/err only report whether
// the host respected the busy window and wrote an address first.
interface jt12_bus_resp_if;
  logic       cs_n;
  logic       wr_n;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       flag_a;
  logic       flag_b;
  logic       up_strobe;
  logic       up_bank;
  logic [7:0] up_addr;
  logic [7:0] up_data;
  logic       busy;
  logic       err;

  modport master (
    output cs_n, wr_n, addr, din, flag_a, flag_b,
    input  dout, up_strobe, up_bank, up_addr, up_data, busy, err
  );

  modport slave (
    input  cs_n, wr_n, addr, din, flag_a, flag_b,
    output dout, up_strobe, up_bank, up_addr, up_data, busy, err
  );
endinterface

// File: rtl/jt12_busy_cnt.sv
// Busy counter: loads BUSY_CYCLES, counts down to zero and holds there.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load_i     : reload the counter (wins over the decrement)
//   busy_o     : high while the count is non-zero
//   cnt_o      : current count
module jt12_busy_cnt
  import jt12_pkg::*;
#(
  parameter int BUSY_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Reload first so a write landing on the final count keeps busy high.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(BUSY_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/jt12_bus_resp.sv
// Chip-side responder for the JT12 CPU bus.
// Turns address/data write pairs into single-cycle register-write strobes
// for the MMR, runs the BUSY window after each accepted data write and
// returns the status byte {busy, 5'b0, flag_b, flag_a} on dout.
// Ports:
//   clk, rst_n : master clock, async active-low reset
//   bus        : jt12_bus_resp_if.slave (CPU bus, timer flags, MMR write port)
//   busy_cnt_o : current busy count, for observation only
module jt12_bus_resp
  import jt12_pkg::*;
#(
  parameter int BUSY_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  jt12_bus_resp_if.slave   bus,
  output logic [CNT_W-1:0] busy_cnt_o
);

  logic       wr_act;
  logic       wr_q;
  logic       wr_ev;
  wr_kind_e   wr_kind;

  logic       addr_vld_q,  addr_vld_d;
  logic       up_bank_q,   up_bank_d;
  logic [7:0] up_addr_q,   up_addr_d;
  logic [7:0] up_data_q,   up_data_d;
  logic       up_strobe_q, up_strobe_d;
  logic       err_q,       err_d;
  logic       flag_a_q;
  logic       flag_b_q;
  logic       load;
  logic       busy;

  assign wr_act  = ~bus.cs_n & ~bus.wr_n;
  // wr_q clears on reset, so a strobe still held as reset releases
  // is seen as a fresh write.
  assign wr_ev   = wr_act & ~wr_q;
  assign wr_kind = wr_kind_e'(bus.addr[ADDR_SEL_BIT]);

  always_comb begin
    addr_vld_d  = addr_vld_q;
    up_bank_d   = up_bank_q;
    up_addr_d   = up_addr_q;
    up_data_d   = up_data_q;
    up_strobe_d = 1'b0;
    err_d       = err_q;
    load        = 1'b0;
    if (wr_ev) begin
      if (wr_kind == WR_ADDR) begin
        // The bank is latched only here; data writes never touch it.
        up_bank_d  = bus.addr[BANK_BIT];
        up_addr_d  = bus.din;
        addr_vld_d = 1'b1;
      end else if (addr_vld_q) begin
        // Accepted even while busy; that case is only flagged.
        up_data_d   = bus.din;
        up_strobe_d = 1'b1;
        load        = 1'b1;
        if (busy) begin
          err_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= 1'b0;
      addr_vld_q  <= 1'b0;
      up_bank_q   <= 1'b0;
      up_addr_q   <= 8'h00;
      up_data_q   <= 8'h00;
      up_strobe_q <= 1'b0;
      err_q       <= 1'b0;
      flag_a_q    <= 1'b0;
      flag_b_q    <= 1'b0;
    end else begin
      wr_q        <= wr_act;
      addr_vld_q  <= addr_vld_d;
      up_bank_q   <= up_bank_d;
      up_addr_q   <= up_addr_d;
      up_data_q   <= up_data_d;
      up_strobe_q <= up_strobe_d;
      err_q       <= err_d;
      flag_a_q    <= bus.flag_a;
      flag_b_q    <= bus.flag_b;
    end
  end

  jt12_busy_cnt #(
    .BUSY_CYCLES (BUSY_CYCLES)
  ) u_busy_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .busy_o (busy),
    .cnt_o  (busy_cnt_o)
  );

  // Every dout bit comes from a register; no input reaches it directly.
  assign bus.dout      = status_byte(busy, flag_b_q, flag_a_q);
  assign bus.busy      = busy;
  assign bus.up_strobe = up_strobe_q;
  assign bus.up_bank   = up_bank_q;
  assign bus.up_addr   = up_addr_q;
  assign bus.up_data   = up_data_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_jt12_bus_resp.sv
module tb_jt12_bus_resp;
  import jt12_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic [CNT_W-1:0] busy_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  jt12_bus_resp_if bus ();

  jt12_bus_resp #(.BUSY_CYCLES(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy_cnt_o (busy_cnt)
  );

  int checks;
  int errors;

  // ---------------- scoreboard of strobes ----------------
  logic [16:0] exp_q[$];   // {bank, addr, data} of expected strobes
  int          str_cnt;    // strobes seen
  int          busy_hi;    // negedges with busy high since last clear
  int          run_len;    // busy negedges since the most recent strobe
  logic        last_bank;
  logic [7:0]  last_addr;
  logic [7:0]  last_data;

  always @(negedge clk) begin
    if (bus.busy) busy_hi++;
    if (bus.up_strobe) begin
      str_cnt++;
      last_bank = bus.up_bank;
      last_addr = bus.up_addr;
      last_data = bus.up_data;
      run_len   = 1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_strobe observed=%0h expected=none",
               {bus.up_bank, bus.up_addr, bus.up_data});
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        assert ({bus.up_bank, bus.up_addr, bus.up_data} === e) else begin
          errors++;
          $error("FAIL strobe_fields observed=%0h expected=%0h",
                 {bus.up_bank, bus.up_addr, bus.up_data}, e);
        end
      end
    end else if (bus.busy) begin
      run_len++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one write, strobe low for 'hold' rising edges; returns on the
  // negedge after the last held edge with the bus released.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d,
                           input int hold);
    @(negedge clk);
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    bus.addr = a;
    bus.din  = d;
    repeat (hold) @(negedge clk);
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int s0;

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0; errors = 0; str_cnt = 0; busy_hi = 0; run_len = 0;
    rst_n = 1'b0;
    bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.addr = 2'b00; bus.din = 8'h00;
    bus.flag_a = 1'b0; bus.flag_b = 1'b0;

    // Reset state
    #12;
    check("rst_dout", bus.dout, 8'h00);
    check("rst_busy", bus.busy, 0);
    check("rst_strobe", bus.up_strobe, 0);
    check("rst_err", bus.err, 0);
    check("rst_fields", {bus.up_bank, bus.up_addr, bus.up_data}, 17'h0);
    @(negedge clk); rst_n = 1'b1;
    idle(5);
    check("idle_no_strobe", str_cnt, 0);
    check("idle_dout", bus.dout, 8'h00);

    // Bank 0 write pair, busy window
    bus_write(2'd0, 8'h28, 1);
    check("addr_wr_no_strobe", str_cnt, 0);
    check("addr_wr_no_busy", bus.busy, 0);
    busy_hi = 0;
    exp_q.push_back({1'b0, 8'h28, 8'hF1});
    bus_write(2'd1, 8'hF1, 1);
    check("data_wr_strobe", str_cnt, 1);
    check("data_wr_busy", bus.busy, 1);
    check("data_wr_dout7", bus.dout, 8'h80);
    check("data_wr_err", bus.err, 0);
    idle(40);
    check("busy_len_32", busy_hi, 32);
    check("busy_run_32", run_len, 32);
    check("dout_after_busy", bus.dout, 8'h00);

    // Bank 1 write pair
    exp_q.push_back({1'b1, 8'hA4, 8'h22});
    bus_write(2'd2, 8'hA4, 1);
    bus_write(2'd3, 8'h22, 1);
    check("bank1_strobe", str_cnt, 2);
    check("bank1_bank", last_bank, 1);
    check("bank1_addr", last_addr, 8'hA4);
    check("bank1_data", last_data, 8'h22);
    idle(40);

    // Strobe held low 10 cycles -> one write
    s0 = str_cnt;
    busy_hi = 0;
    exp_q.push_back({1'b1, 8'hA4, 8'h55});
    bus_write(2'd3, 8'h55, 10);
    idle(40);
    check("held_one_strobe", str_cnt - s0, 1);
    check("held_busy_32", busy_hi, 32);
    check("held_err", bus.err, 0);

    // Second data write inside the busy window: first strobe seen at N0,
    // second write's edge lands six cycles later, so busy stays high for
    // 6 + 32 negedges with no gap.
    s0 = str_cnt;
    busy_hi = 0;
    exp_q.push_back({1'b1, 8'hA4, 8'h11});
    exp_q.push_back({1'b1, 8'hA4, 8'h12});
    bus_write(2'd3, 8'h11, 1);
    repeat (4) @(negedge clk);
    bus_write(2'd3, 8'h12, 1);
    check("rebusy_strobe", str_cnt - s0, 2);
    check("rebusy_err", bus.err, 1);
    check("rebusy_data", last_data, 8'h12);
    idle(45);
    check("rebusy_run_32", run_len, 32);
    check("rebusy_total_38", busy_hi, 38);

    // Flags registered once
    @(negedge clk);
    bus.flag_a = 1'b1; bus.flag_b = 1'b0;
    #1;
    check("flag_not_comb", bus.dout, 8'h00);
    idle(1);
    check("flag_a_dout", bus.dout, 8'h01);
    bus.flag_a = 1'b0; bus.flag_b = 1'b1;
    idle(1);
    check("flag_b_dout", bus.dout, 8'h02);
    bus.flag_b = 1'b0;
    idle(1);

    // Async reset clears err; then a data write with no address latched
    #2 rst_n = 1'b0;
    #1;
    check("rst_err_clear", bus.err, 0);
    check("rst_addr_clear", bus.up_addr, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    s0 = str_cnt;
    bus_write(2'd1, 8'h33, 1);
    idle(3);
    check("noaddr_no_strobe", str_cnt - s0, 0);
    check("noaddr_err", bus.err, 1);
    check("noaddr_busy", bus.busy, 0);

    // Reset mid-busy with err set
    exp_q.push_back({1'b0, 8'h10, 8'h01});
    exp_q.push_back({1'b0, 8'h10, 8'h02});
    bus_write(2'd0, 8'h10, 1);
    bus_write(2'd1, 8'h01, 1);
    idle(3);
    bus_write(2'd1, 8'h02, 1);
    idle(3);
    check("midbusy_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_err", bus.err, 0);
    check("midrst_dout", bus.dout, 8'h00);
    check("midrst_cnt", busy_cnt, 0);

    // Write strobe held through reset release -> one new address write;
    // a following data write on addr=3 must keep bank 0.
    bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.addr = 2'd0; bus.din = 8'h5A;
    @(negedge clk); rst_n = 1'b1;
    idle(3);
    bus.cs_n = 1'b1; bus.wr_n = 1'b1;
    check("held_rst_addr", bus.up_addr, 8'h5A);
    s0 = str_cnt;
    exp_q.push_back({1'b0, 8'h5A, 8'h77});
    bus_write(2'd3, 8'h77, 1);
    check("iso_strobe", str_cnt - s0, 1);
    check("iso_bank", last_bank, 0);
    check("iso_err", bus.err, 0);
    idle(40);

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
